// File: rtl/serial_add_sched.sv
// Scheduler that lets two requesters share one bit-serial adder: arbitrate, clear, load, shift WIDTH times, report.
// Define SERIAL_ADD_SCHED_FIXED_PRIO_EN to make requester 0 win every tie (no last-served pointer).
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             adder_rst,
    output logic             adder_load,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH-1:0] adder_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pick;

`ifdef SERIAL_ADD_SCHED_FIXED_PRIO_EN
    always_comb begin
        pick = ~req[0];
    end
`else
    logic last_served;

    // On a tie, the requester that was not served last gets the adder.
    always_comb begin
        pick = ~req[0];
        if (req == 2'b11)
            pick = ~last_served;
    end
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt        <= 2'b00;
            done       <= 2'b00;
            result     <= '0;
            adder_a    <= '0;
            adder_b    <= '0;
            adder_load <= 1'b0;
            adder_rst  <= 1'b1;
`ifndef SERIAL_ADD_SCHED_FIXED_PRIO_EN
            last_served <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    adder_rst  <= 1'b1;
                    adder_load <= 1'b0;
                    if (|req) begin
                        gnt     <= pick ? 2'b10 : 2'b01;
                        adder_a <= pick ? a1 : a0;
                        adder_b <= pick ? b1 : b0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    adder_rst  <= 1'b0;
                    adder_load <= 1'b1;
                    state      <= LOAD;
                end
                LOAD: begin
                    adder_load <= 1'b0;
                    cnt        <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cnt    <= '0;
                        result <= adder_out;
                        done   <= gnt;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done      <= 2'b00;
                    gnt       <= 2'b00;
                    adder_rst <= 1'b1;
                    state     <= IDLE;
`ifndef SERIAL_ADD_SCHED_FIXED_PRIO_EN
                    last_served <= gnt[1];
`endif
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    gnt        <= 2'b00;
                    done       <= 2'b00;
                    adder_load <= 1'b0;
                    adder_rst  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: a bit-serial adder environment plus a transaction-level model
// (round-robin winner, modulo-256 sum, fixed done latency).
module tb_serial_add_sched;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         rst   = 1'b1;
    logic [1:0]   req   = 2'b00;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   gnt, done;
    logic [W-1:0] result, adder_a, adder_b, adder_out;
    logic         busy, adder_rst, adder_load;

    int vectors     = 0;
    int miscompares = 0;
    int last_srv    = 1;
    logic [W-1:0] prev_result = '0;

    always #5 clock = ~clock;

    serial_add_sched #(.WIDTH(W)) dut (
        .clock(clock), .rst(rst), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .done(done), .result(result), .busy(busy),
        .adder_rst(adder_rst), .adder_load(adder_load),
        .adder_a(adder_a), .adder_b(adder_b), .adder_out(adder_out)
    );

    // Shared bit-serial adder: LSB first, sum bits enter the SIPO at the MSB.
    // Its parallel output presents the bit being formed this cycle, so the full
    // sum is visible during the last shift cycle.
    logic [W-1:0] sa, sb, sipo;
    logic         cy, sbit;
    assign sbit      = sa[0] ^ sb[0] ^ cy;
    assign adder_out = {sbit, sipo[W-1:1]};

    always_ff @(posedge clock) begin
        if (adder_rst) begin
            sa <= '0; sb <= '0; sipo <= '0; cy <= 1'b0;
        end else if (adder_load) begin
            sa <= adder_a; sb <= adder_b; cy <= 1'b0;
        end else begin
            sa   <= sa >> 1;
            sb   <= sb >> 1;
            sipo <= {sbit, sipo[W-1:1]};
            cy   <= (sa[0] & sb[0]) | (cy & (sa[0] ^ sb[0]));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int pick_winner(input logic [1:0] r);
`ifdef SERIAL_ADD_SCHED_FIXED_PRIO_EN
        return r[0] ? 0 : 1;
`else
        if (r == 2'b11) return (last_srv == 1) ? 0 : 1;
        return r[0] ? 0 : 1;
`endif
    endfunction

    function automatic logic [1:0] onehot(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    // Reset asserted mid-cycle; outputs must clear before the next clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_gnt",   32'(gnt), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_adder_rst", 32'(adder_rst), 32'd1);
        chk("rst_adder_load", 32'(adder_load), 32'd0);
        chk("rst_adder_ab", 32'({adder_a, adder_b}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        last_srv    = 1;
        prev_result = '0;
    endtask

    // One full transaction, entered at edge+1 with the DUT idle.
    task automatic transact(input logic [1:0] r, input logic [W-1:0] x0, input logic [W-1:0] y0,
                            input logic [W-1:0] x1, input logic [W-1:0] y1, input bit drop);
        int w;
        logic [W-1:0] exp_sum;
        req = r; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        w = pick_winner(r);
        exp_sum = (w == 1) ? W'(int'(x1) + int'(y1)) : W'(int'(x0) + int'(y0));
        tick();
        chk("grant", 32'(gnt), 32'(onehot(w)));
        chk("busy_after_grant", 32'(busy), 32'd1);
        chk("clear_strobes", 32'({adder_rst, adder_load}), 32'b10);
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        if (drop) req = 2'b00;
        tick();
        chk("load_strobes", 32'({adder_rst, adder_load}), 32'b01);
        repeat (8) tick();
        chk("no_early_done", 32'(done), 32'd0);
        chk("result_held", 32'(result), 32'(prev_result));
        tick();
        chk("done_pulse", 32'(done), 32'(onehot(w)));
        chk("gnt_in_done", 32'(gnt), 32'(onehot(w)));
        chk("sum", 32'(result), 32'(exp_sum));
        tick();
        chk("done_cleared", 32'(done), 32'd0);
        chk("gnt_cleared", 32'(gnt), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_adder_rst", 32'(adder_rst), 32'd1);
        last_srv    = w;
        prev_result = exp_sum;
    endtask

    initial begin
        tick();
        do_reset();

        // Single requester with a known sum, then the wrap-around case.
        transact(2'b01, 8'h2B, 8'h14, 8'h00, 8'h00, 1'b0);
        transact(2'b01, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0);

        // Reset during the 4th SHIFT cycle aborts the add silently.
        do_reset();
        req = 2'b01; a0 = 8'h55; b0 = 8'h22;
        tick();
        chk("abort_grant", 32'(gnt), 32'd1);
        req = 2'b00;
        repeat (5) tick();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_done", 32'({done, busy}), 32'd0);
            tick();
        end
        chk("abort_result", 32'(result), 32'd0);
        transact(2'b01, 8'h55, 8'h22, 8'h00, 8'h00, 1'b0);

        // Both requesting continuously from a fresh reset.
        do_reset();
        transact(2'b11, 8'h01, 8'h02, 8'h10, 8'h20, 1'b0);
        transact(2'b11, 8'h01, 8'h02, 8'h10, 8'h20, 1'b0);
        transact(2'b11, 8'h01, 8'h02, 8'h10, 8'h20, 1'b0);

        // Requester drops req right after grant; operands scrambled.
        transact(2'b01, 8'h3C, 8'h41, 8'h00, 8'h00, 1'b1);
        repeat (3) tick();
        chk("stays_idle", 32'({gnt, busy}), 32'd0);

        for (int n = 0; n < 24; n++) begin
            transact(2'($urandom_range(1, 3)), W'($urandom), W'($urandom),
                     W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_sched.md
SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width and number of shift cycles per add.
REQ-002 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous and active-high.
REQ-004 Port: req  in  2  per-requester add request; bit i belongs to requester i.
REQ-005 Port: a0, b0 / a1, b1  in  WIDTH each  operands of requester 0 / requester 1.
REQ-006 Port: gnt  out  2  one-hot registered grant; marks the requester owning the adder.
REQ-007 Port: done  out  2  one-cycle completion pulse to the granted requester.
REQ-008 Port: result  out  WIDTH  sum of the last completed add, held until the next completion.
REQ-009 Port: busy  out  1  high whenever the state is not IDLE.
REQ-010 Port: adder_rst  out  1  clears the shared serial adder's shift registers and carry flop.
REQ-011 Port: adder_load  out  1  parallel-load strobe to the serial adder.
REQ-012 Port: adder_a, adder_b  out  WIDTH  registered operands presented to the serial adder.
REQ-013 Port: adder_out  in  WIDTH  parallel output of the serial adder's SIPO register.

Function
REQ-014 States: IDLE, CLEAR, LOAD, SHIFT, DONE, one-hot or binary encoded, with no other reachable states.
REQ-015 IDLE: when any req bit is high at a rising edge, the arbiter picks a winner, sets gnt, latches its operands into adder_a/adder_b, and moves to CLEAR; otherwise it stays in IDLE.
REQ-016 Arbitration is round-robin: if both request, the requester not served last wins; a single requester always wins.
REQ-017 CLEAR lasts one cycle with adder_rst=1, then LOAD.
REQ-018 LOAD lasts one cycle with adder_load=1, then SHIFT with the shift counter at 0.
REQ-019 SHIFT lasts exactly WIDTH cycles with adder_load=0 and adder_rst=0; the counter increments every cycle.
REQ-020 At the edge where the counter equals WIDTH-1: result <= adder_out, state <= DONE.
REQ-021 DONE lasts one cycle: done[winner]=1, gnt still held; then IDLE with gnt=0 and the last-served pointer updated.
REQ-022 Latency: done rises WIDTH+2 cycles after the edge that sampled req (10 for WIDTH=8); back-to-back grants are separated by one IDLE cycle.
REQ-023 Operands are latched at grant; changes to req, a*, or b* after grant do not affect the operation in flight.
REQ-024 A requester dropping req after grant does not abort the operation; its done pulse is still issued.
REQ-025 Arithmetic is modulo 2^WIDTH; the final carry is discarded.
REQ-026 Outside CLEAR and LOAD, adder_rst=0 and adder_load=0; in IDLE, adder_rst=1 so the adder is held cleared.

Reset
REQ-027 Asserting rst immediately forces: state IDLE, gnt=0, done=0, busy=0, result=0, adder_a=0, adder_b=0, adder_load=0, adder_rst=1, counter=0.
REQ-028 After reset, the last-served pointer points at requester 1, so requester 0 wins the first tie.
REQ-029 A reset during any non-IDLE state aborts the operation with no done pulse and no result update.

Configuration
REQ-030 Macro SERIAL_ADD_SCHED_FIXED_PRIO_EN: when defined, requester 0 always wins ties and the last-served pointer is removed; when undefined, arbitration is round-robin per REQ-016.

Verification
REQ-031 After reset, req=01, a0=8'h2B, b0=8'h14 -> gnt=01 next cycle; done=01 10 cycles after the sampling edge; result=8'h3F.
REQ-032 req=11 held continuously, a0=8'h01, b0=8'h02, a1=8'h10, b1=8'h20 -> grants alternate 01,10,01; results alternate 8'h03, 8'h30.
REQ-033 req0 with a0=8'hFF, b0=8'h01 -> result=8'h00, with no extra output or flag.
REQ-034 rst pulsed during the 4th SHIFT cycle -> gnt=0 and busy=0 immediately, no done pulse, result unchanged at 0; a subsequent req0 completes normally.
REQ-035 With SERIAL_ADD_SCHED_FIXED_PRIO_EN defined and req=11 held -> gnt=01 on every grant; requester 1 is served only after req0 drops.
REQ-036 req0 asserted one cycle then dropped, and a0 changed after grant -> done0 still pulses and result reflects the operands latched at grant.
